// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequencer between the MEM stage and the 64-bit data memory port.
//   It accepts one load/store at a time. Stores are shifted into byte lanes
//   and given write strobes. Loads are extracted and then sign- or
//   zero-extended. Misaligned accesses and bus timeouts come back as errors.
//   Every accepted request produces exactly one resp_valid pulse.
//
// Ports
//   clk, rstn              clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake from the MEM stage (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_width   access description (width: 000 none, 001 d, 010 w,
//                          011 h, 100 b, 101 wu, 110 hu, 111 bu)
//   mem_req/mem_gnt        memory request handshake
//   mem_addr, mem_wen,
//   mem_wdata, mem_wmask   doubleword-aligned request, lane-shifted data, strobes
//   mem_rvalid, mem_rdata  memory read return
//   resp_valid, resp_rdata,
//   resp_err               one-cycle response to the MEM stage
//
// Parameter
//   TIMEOUT                cycles allowed in REQ or WAIT before abort (0 = never)

module mem_access_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_width,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e        state_q;
    logic          we_q;
    logic [2:0]    width_q;
    logic [2:0]    off_q;
    logic [63:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          drop_q;
    logic          mem_req_q;
    logic [63:0]   mem_addr_q;
    logic          mem_wen_q;
    logic [63:0]   mem_wdata_q;
    logic [7:0]    mem_wmask_q;
    logic          resp_valid_q;
    logic [63:0]   resp_rdata_q;
    logic          resp_err_q;

    logic [2:0]  off_in;
    logic        misalign_d;
    logic [7:0]  size_mask_d;
    logic [63:0] keep_d;
    logic [63:0] wdata_d;
    logic [7:0]  wmask_d;
    logic [63:0] shifted_d;
    logic [63:0] ext_d;
    logic        to_hit;

    assign off_in = req_addr[2:0];

    // Store lane placement, computed from the incoming request.
    always_comb begin
        misalign_d  = 1'b0;
        size_mask_d = 8'h00;
        keep_d      = 64'h0;
        case (req_width)
            3'b001: begin
                misalign_d  = |off_in;
                size_mask_d = 8'hFF;
                keep_d      = req_wdata;
            end
            3'b010, 3'b101: begin
                misalign_d  = |off_in[1:0];
                size_mask_d = 8'h0F;
                keep_d      = {32'h0, req_wdata[31:0]};
            end
            3'b011, 3'b110: begin
                misalign_d  = off_in[0];
                size_mask_d = 8'h03;
                keep_d      = {48'h0, req_wdata[15:0]};
            end
            3'b100, 3'b111: begin
                size_mask_d = 8'h01;
                keep_d      = {56'h0, req_wdata[7:0]};
            end
            default: ;
        endcase
        wdata_d = keep_d << {off_in, 3'b000};
        wmask_d = size_mask_d << off_in;
    end

    // Load extraction, using the captured offset and width.
    always_comb begin
        shifted_d = mem_rdata >> {off_q, 3'b000};
        case (width_q)
            3'b001:  ext_d = shifted_d;
            3'b010:  ext_d = {{32{shifted_d[31]}}, shifted_d[31:0]};
            3'b011:  ext_d = {{48{shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  ext_d = {{56{shifted_d[7]}},  shifted_d[7:0]};
            3'b101:  ext_d = {32'h0, shifted_d[31:0]};
            3'b110:  ext_d = {48'h0, shifted_d[15:0]};
            3'b111:  ext_d = {56'h0, shifted_d[7:0]};
            default: ext_d = 64'h0;
        endcase
    end

    // Fires on the TIMEOUT-th cycle spent in REQ/WAIT. A handshake on the
    // same edge is checked first, so it wins.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            width_q      <= 3'b000;
            off_q        <= 3'b000;
            rdata_q      <= 64'h0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 64'h0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= 64'h0;
            mem_wmask_q  <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'h0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'h0;
            resp_err_q   <= 1'b0;

            // A stale return from an aborted load is swallowed wherever it
            // lands. A fresh WAIT abort below re-arms the flag.
            if (drop_q && mem_rvalid) drop_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        width_q <= req_width;
                        off_q   <= off_in;
                        rdata_q <= 64'h0;
                        if (req_width == 3'b000) begin
                            err_q   <= 1'b0;
                            state_q <= S_RESP;
                        end else if (misalign_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            err_q       <= 1'b0;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {req_addr[63:3], 3'b000};
                            mem_wen_q   <= req_we;
                            mem_wdata_q <= req_we ? wdata_d : 64'h0;
                            mem_wmask_q <= req_we ? wmask_d : 8'h00;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt || to_hit) begin
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= 64'h0;
                        mem_wen_q   <= 1'b0;
                        mem_wdata_q <= 64'h0;
                        mem_wmask_q <= 8'h00;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (mem_gnt) begin
                        state_q <= we_q ? S_RESP : S_WAIT;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid && !drop_q) begin
                        rdata_q <= ext_d;
                        state_q <= S_RESP;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        drop_q  <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= rdata_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TO = 4;
    localparam logic [63:0] JUNK = 64'hDEAD;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_width;
    logic        mem_req, mem_gnt, mem_wen, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;

    int ncmp = 0;
    int nerr = 0;
    bit stale = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: which bytes move where, then extension.
    function automatic void model(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                                  input logic [2:0] width, input logic [63:0] rd,
                                  output logic acc, output logic err, output logic [63:0] rdata,
                                  output logic [63:0] wdata, output logic [7:0] wmask);
        int sz;
        int off;
        bit sgn;
        case (width)
            3'd1:       sz = 8;
            3'd2, 3'd5: sz = 4;
            3'd3, 3'd6: sz = 2;
            3'd4, 3'd7: sz = 1;
            default:    sz = 0;
        endcase
        sgn = (width == 3'd2) || (width == 3'd3) || (width == 3'd4);
        off = int'(addr[2:0]);
        acc = 1'b0; err = 1'b0; rdata = 64'h0; wdata = 64'h0; wmask = 8'h0;
        if (sz == 0) return;
        if (off % sz != 0) begin
            err = 1'b1;
            return;
        end
        acc = 1'b1;
        for (int i = 0; i < sz; i++) begin
            if (we) begin
                wmask[off+i] = 1'b1;
                wdata[8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                rdata[8*i +: 8] = rd[8*(off+i) +: 8];
            end
        end
        if (!we && sgn && rdata[8*sz-1])
            for (int i = 8*sz; i < 64; i++) rdata[i] = 1'b1;
    endfunction

    // One transaction. g = cycles mem_req is left waiting before gnt;
    // r = extra cycles after the gnt edge before rvalid.
    task automatic run(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [2:0] width,
                       input int g, input int r, input logic [63:0] rd);
        logic acc, err, seen, stab, to_req, to_wait;
        logic [63:0] exp_rd, exp_wd, a0, d0;
        logic [7:0] exp_wm, m0;
        logic w0;
        int exp_cyc, resp_cyc, n_req, gnt_edge, k;
        model(we, addr, wd, width, rd, acc, err, exp_rd, exp_wd, exp_wm);
        to_req  = acc && (g >= TO);
        to_wait = acc && !we && !to_req && (r >= TO);
        if (!acc)         exp_cyc = 1;
        else if (to_req)  exp_cyc = TO + 1;
        else if (we)      exp_cyc = g + 2;
        else if (to_wait) exp_cyc = g + TO + 2;
        else              exp_cyc = g + r + 3;
        if (to_req || to_wait) begin
            err = 1'b1;
            exp_rd = 64'h0;
        end

        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_width = width;
        @(posedge clk); #1;
        // Scramble request inputs to check they were captured.
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom}; req_width = 3'($urandom);

        n_req = 0; gnt_edge = -1; seen = 1'b0; stab = 1'b1; resp_cyc = -1;
        a0 = 64'h0; d0 = 64'h0; m0 = 8'h0; w0 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_gnt) gnt_edge = c;
            if (resp_valid) begin
                resp_cyc = c;
                break;
            end
            if (mem_req) begin
                if (!seen) begin
                    a0 = mem_addr; d0 = mem_wdata; m0 = mem_wmask; w0 = mem_wen;
                end else if (mem_addr !== a0 || mem_wdata !== d0 || mem_wmask !== m0 || mem_wen !== w0) begin
                    stab = 1'b0;
                end
                seen = 1'b1;
                n_req++;
            end
            mem_gnt = mem_req && (n_req > g);
            if (c == 0 && stale) begin
                mem_rvalid = 1'b1; mem_rdata = JUNK;
            end else if (!to_wait && gnt_edge >= 0 && c + 1 == gnt_edge + 1 + r) begin
                mem_rvalid = 1'b1; mem_rdata = rd;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        chk({tag, ".resp_cyc"}, 64'(resp_cyc), 64'(exp_cyc));
        chk({tag, ".err"}, 64'(resp_err), 64'(err));
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".access"}, 64'(seen), 64'(acc));
        if (acc && seen) begin
            chk({tag, ".addr"}, a0, addr & ~64'h7);
            chk({tag, ".wen"}, 64'(w0), 64'(we));
            chk({tag, ".stable"}, 64'(stab), 64'd1);
            if (we) begin
                chk({tag, ".wdata"}, d0, exp_wd);
                chk({tag, ".wmask"}, 64'(m0), 64'(exp_wm));
            end
        end
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(resp_valid), 64'd0);
        chk({tag, ".idle"}, 64'(req_ready), 64'd1);
        stale = to_wait;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
        req_width = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.outs", {mem_addr | mem_wdata | resp_rdata}, 64'd0);
        chk("rst.misc", 64'({mem_wmask, mem_wen, resp_err}), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run("sb", 1'b1, 64'h1003, 64'hABCD_EF12, 3'b100, 0, 0, 64'h0);
        run("lb", 1'b0, 64'h2006, 64'h0, 3'b100, 0, 0, 64'h0080_0000_0000_0000);
        run("lbu", 1'b0, 64'h2006, 64'h0, 3'b111, 0, 0, 64'h0080_0000_0000_0000);
        run("lw", 1'b0, 64'h3004, 64'h0, 3'b010, 3, 2, 64'h8000_0001_0000_0000);
        run("lh_mis", 1'b0, 64'h4001, 64'h0, 3'b011, 0, 0, 64'h0);
        run("none", 1'b0, 64'h5000, 64'h0, 3'b000, 0, 0, 64'h0);
        run("ld_to", 1'b0, 64'h6000, 64'h0, 3'b001, 0, 100, 64'h0);
        run("ld_after", 1'b0, 64'h6008, 64'h0, 3'b001, 0, 1, 64'h1234);
        run("sd_gto", 1'b1, 64'h7000, 64'h55, 3'b001, TO, 0, 64'h0);
        run("sh_edge", 1'b1, 64'h7006, 64'hBEEF, 3'b110, TO - 1, 0, 64'h0);
        run("lhu_edge", 1'b0, 64'h7002, 64'h0, 3'b110, 0, TO - 1, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 0) a[2:0] = 3'b000;
            run("rand", 1'($urandom), a, {$urandom, $urandom}, 3'($urandom),
                int'($urandom_range(TO + 1, 0)), int'($urandom_range(TO + 1, 0)),
                {$urandom, $urandom});
        end

        // Asynchronous reset while a load sits in WAIT.
        while (stale) run("flush", 1'b0, 64'h8000, 64'h0, 3'b001, 0, 0, 64'h1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h9000; req_width = 3'b001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("rstw.in_wait", 64'(req_ready), 64'd0);
        #2 rstn = 1'b0;
        #1;
        chk("rstw.ready", 64'(req_ready), 64'd1);
        chk("rstw.outs", 64'({mem_req, mem_wen, mem_wmask, resp_valid, resp_err}), 64'd0);
        chk("rstw.data", mem_addr | mem_wdata | resp_rdata, 64'd0);
        @(posedge clk); #3;
        rstn = 1'b1;
        stale = 1'b0;
        @(posedge clk); #1;
        run("sd_post", 1'b1, 64'hA008, 64'h0123_4567_89AB_CDEF, 3'b001, 1, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
